// File: rtl/serial_pkg.sv
// serial_pkg: types and line levels shared by the serial word capture block.
//   state_t      - capture FSM state, 2-bit encoding IDLE=0 DATA=1 PARITY=2 STOP=3
//   START_LEVEL  - line level of a start bit
//   STOP_LEVEL   - line level of a good stop bit
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_word_capture_if.sv
// serial_word_capture_if: serial input strobe and one-entry output buffer.
//   din, en      - serial bit and its strobe (din consumed only when en=1)
//   dout         - captured word, held while dout_valid=1
//   dout_valid   - dout holds an unconsumed word
//   dout_ready   - consumer accepts dout
//   parity_err   - status of the held word
//   framing_err  - one-cycle pulse on a bad stop bit
//   overrun      - one-cycle pulse when a good frame is dropped
//
// Handshake: a word transfers on a posedge where dout_valid=1 and dout_ready=1.
// dout_valid never drops without a transfer, dout is stable while dout_valid=1,
// and dout_ready is ignored while dout_valid=0.
interface serial_word_capture_if #(
  parameter int WIDTH = 8
);
  logic             din;
  logic             en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             parity_err;
  logic             framing_err;
  logic             overrun;

  modport master (
    output din, en, dout_ready,
    input  dout, dout_valid, parity_err, framing_err, overrun
  );

  modport slave (
    input  din, en, dout_ready,
    output dout, dout_valid, parity_err, framing_err, overrun
  );
endinterface

// File: rtl/shift_reg_en.sv
// shift_reg_en: WIDTH-bit right-shift register with enable.
//   clk, reset - clock and synchronous active-high reset (clears to 0)
//   en_i       - shift when 1
//   d_i        - bit shifted in at the MSB
//   q_o        - register contents; first bit shifted in ends in bit 0
module shift_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shreg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (en_i) begin
      shreg_q <= {d_i, shreg_q[WIDTH-1:1]};
    end
  end

  assign q_o = shreg_q;

endmodule

// File: rtl/serial_word_capture.sv
// serial_word_capture: frames a strobed serial bit stream as
// start / WIDTH data bits (LSB first) / optional even parity / stop and
// presents each good word in a one-entry valid/ready buffer.
//   clk, reset - clock and synchronous active-high reset
//   bus        - serial input and output buffer (slave side)
//   state_dbg  - current FSM state
module serial_word_capture
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_word_capture_if.slave  bus,
  output state_t                state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pbit_q, pbit_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             frame_good;
  logic             frame_bad;
  logic             parity_calc;
  logic [WIDTH-1:0] shreg;

  shift_reg_en #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .en_i  (shift_en),
    .d_i   (bus.din),
    .q_o   (shreg)
  );

  // During the stop strobe shreg already holds the full word, so the
  // status can be computed combinationally and loaded alongside it.
  assign parity_calc = (PARITY_EN != 0) ? (^shreg ^ pbit_q) : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pbit_q  <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pbit_q  <= pbit_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Frame FSM: every transition needs a strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pbit_d     = pbit_q;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.din == START_LEVEL) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          pbit_d  = bus.din;
          state_d = STOP;
        end
        STOP: begin
          if (bus.din == STOP_LEVEL) frame_good = 1'b1;
          else                       frame_bad  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output buffer: a completing frame may reuse the slot in the same
  // cycle the held word is taken.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = frame_bad;
    ovr_d   = 1'b0;
    if (valid_q && bus.dout_ready) begin
      valid_d = 1'b0;
    end
    if (frame_good) begin
      if (!valid_q || bus.dout_ready) begin
        dout_d  = shreg;
        perr_d  = parity_calc;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.dout        = dout_q;
  assign bus.dout_valid  = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun     = ovr_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_serial_word_capture.sv
// tb_serial_word_capture: directed bench for an 8-bit parity build (A) and a
// 5-bit no-parity build (B) of serial_word_capture.
module tb_serial_word_capture;
  import serial_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_word_capture_if #(.WIDTH(8)) bus_a ();
  serial_word_capture_if #(.WIDTH(5)) bus_b ();
  state_t st_a, st_b;

  serial_word_capture #(.WIDTH(8), .PARITY_EN(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .state_dbg (st_a)
  );

  serial_word_capture #(.WIDTH(5), .PARITY_EN(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .state_dbg (st_b)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_p_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] o_dout(int sel);
    return (sel != 0) ? W'(bus_b.dout) : W'(bus_a.dout);
  endfunction
  function automatic logic o_valid(int sel);
    return (sel != 0) ? bus_b.dout_valid : bus_a.dout_valid;
  endfunction
  function automatic logic o_perr(int sel);
    return (sel != 0) ? bus_b.parity_err : bus_a.parity_err;
  endfunction
  function automatic logic o_ferr(int sel);
    return (sel != 0) ? bus_b.framing_err : bus_a.framing_err;
  endfunction
  function automatic logic o_ovr(int sel);
    return (sel != 0) ? bus_b.overrun : bus_a.overrun;
  endfunction

  // ---------------- drivers ----------------
  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(int sel, logic d, logic e, logic r);
    bus_a.din        = d;
    bus_b.din        = d;
    bus_a.en         = e && (sel == 0);
    bus_b.en         = e && (sel != 0);
    bus_a.dout_ready = r;
    bus_b.dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(int sel, logic b, int gap, logic rdy);
    repeat (gap) cyc(sel, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(sel, b, 1'b1, rdy);
  endtask

  task automatic send_frame(int sel, logic [W-1:0] w, int width, bit par_en,
                            bit par_flip, logic stop, int gap, logic rdy_stop,
                            bit expect_load);
    logic p;
    p = 1'b0;
    for (int i = 0; i < width; i++) p ^= w[i];
    p ^= par_flip;
    if (expect_load) begin
      exp_q.push_back(w);
      exp_p_q.push_back(par_en && par_flip);
    end
    send_bit(sel, 1'b0, gap, 1'b0);
    for (int i = 0; i < width; i++) send_bit(sel, w[i], gap, 1'b0);
    if (par_en) send_bit(sel, p, gap, 1'b0);
    send_bit(sel, stop, gap, rdy_stop);
  endtask

  task automatic check_out(int sel, string tag);
    logic [W-1:0] w;
    logic p;
    chk({tag, "_sb_nonempty"}, W'(exp_q.size() > 0), W'(1));
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      p = exp_p_q.pop_front();
      chk({tag, "_dout"}, o_dout(sel), w);
      chk({tag, "_valid"}, W'(o_valid(sel)), W'(1));
      chk({tag, "_perr"}, W'(o_perr(sel)), W'(p));
      chk({tag, "_ferr"}, W'(o_ferr(sel)), W'(0));
      chk({tag, "_ovr"}, W'(o_ovr(sel)), W'(0));
    end
  endtask

  task automatic consume(int sel, string tag);
    cyc(sel, 1'b1, 1'b0, 1'b1);
    chk({tag, "_consumed"}, W'(o_valid(sel)), W'(0));
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_a_dout"}, o_dout(0), W'(0));
    chk({tag, "_a_valid"}, W'(o_valid(0)), W'(0));
    chk({tag, "_a_perr"}, W'(o_perr(0)), W'(0));
    chk({tag, "_a_ferr"}, W'(o_ferr(0)), W'(0));
    chk({tag, "_a_ovr"}, W'(o_ovr(0)), W'(0));
    chk({tag, "_a_state"}, W'(st_a), W'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    check_reset("reset");
    chk("reset_b_valid", W'(o_valid(1)), W'(0));
    chk("reset_b_state", W'(st_b), W'(IDLE));

    // Idle strobes with din=1 must not start a frame.
    cyc(0, 1'b1, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b0);
    chk("idle_high", W'(st_a), W'(IDLE));

    // Good frame with even parity.
    send_frame(0, W'(8'hA5), 8, 1, 0, 1'b1, 0, 1'b0, 1);
    check_out(0, "a5");
    consume(0, "a5");
    chk("a5_dout_kept", o_dout(0), W'(8'hA5));

    // Parity error is buffered, then a bad stop leaves the buffer alone.
    send_frame(0, W'(8'h3C), 8, 1, 1, 1'b1, 0, 1'b0, 1);
    check_out(0, "3c_perr");
    send_frame(0, W'(8'h77), 8, 1, 0, 1'b0, 0, 1'b0, 0);
    chk("frm_ferr", W'(o_ferr(0)), W'(1));
    chk("frm_valid", W'(o_valid(0)), W'(1));
    chk("frm_dout", o_dout(0), W'(8'h3C));
    chk("frm_ovr", W'(o_ovr(0)), W'(0));
    chk("frm_state", W'(st_a), W'(IDLE));
    cyc(0, 1'b1, 1'b0, 1'b0);
    chk("frm_ferr_pulse", W'(o_ferr(0)), W'(0));
    consume(0, "3c");

    // Overrun, then a frame completing in the same cycle as a consume.
    send_frame(0, W'(8'h11), 8, 1, 0, 1'b1, 0, 1'b0, 1);
    check_out(0, "11");
    send_frame(0, W'(8'h22), 8, 1, 0, 1'b1, 0, 1'b0, 0);
    chk("ovr_pulse", W'(o_ovr(0)), W'(1));
    chk("ovr_dout", o_dout(0), W'(8'h11));
    chk("ovr_valid", W'(o_valid(0)), W'(1));
    cyc(0, 1'b1, 1'b0, 1'b0);
    chk("ovr_one_cycle", W'(o_ovr(0)), W'(0));
    send_frame(0, W'(8'h22), 8, 1, 0, 1'b1, 0, 1'b1, 1);
    check_out(0, "22_swap");
    consume(0, "22");

    // Sparse strobes with din toggling between them.
    send_frame(0, W'(8'h5A), 8, 1, 0, 1'b1, 4, 1'b0, 1);
    check_out(0, "5a_sparse");
    consume(0, "5a");

    // Back-to-back frames, the second taking the slot as the first leaves.
    send_frame(0, W'(8'h0F), 8, 1, 0, 1'b1, 0, 1'b0, 1);
    check_out(0, "0f");
    send_frame(0, W'(8'hF0), 8, 1, 0, 1'b1, 0, 1'b1, 1);
    check_out(0, "f0_b2b");
    consume(0, "f0");

    // Reset mid-frame with a word held, en and ready active.
    send_frame(0, W'(8'h99), 8, 1, 0, 1'b1, 0, 1'b0, 1);
    check_out(0, "99");
    send_bit(0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0, 1'b0);
    chk("mid_state", W'(st_a), W'(DATA));
    reset = 1'b1;
    cyc(0, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    check_reset("midrst");
    send_frame(0, W'(8'hC3), 8, 1, 0, 1'b1, 0, 1'b0, 1);
    check_out(0, "c3");
    consume(0, "c3");

    // No-parity 5-bit build: valid on the edge after the stop strobe.
    send_frame(1, W'(5'h13), 5, 0, 0, 1'b1, 0, 1'b0, 1);
    check_out(1, "b_13");
    consume(1, "b_13");
    send_frame(1, W'(5'h0A), 5, 0, 0, 1'b1, 2, 1'b0, 1);
    check_out(1, "b_0a");
    consume(1, "b_0a");
    chk("a_untouched", W'(o_valid(0)), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_capture.md
# serial_word_capture

Serial-to-parallel capture stage that sits directly downstream of the workshop's registered D flip-flop data path. It consumes the single-bit registered Q stream, one bit per enable strobe, and frames it as start / WIDTH data bits (LSB first) / optional even-parity / stop. Each good word is presented on a one-entry valid/ready output buffer, with parity, framing and overrun status.

## Interface
- WIDTH, 8, data bits per frame (2..32)
- PARITY_EN, 1, 1 = an even-parity bit follows the data bits; 0 = no parity bit

- clk  input  1  system clock; all state changes on posedge clk
- reset  input  1  synchronous, active-high reset; sampled on posedge clk
- din  input  1  serial bit, taken from the upstream flip-flop's Q
- en  input  1  bit strobe; din is consumed only in cycles where en=1
- dout  output  WIDTH  captured data word, held while dout_valid=1
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle when dout_valid=1
- parity_err  output  1  status for the held word; meaningful only while dout_valid=1; 0 when PARITY_EN=0
- framing_err  output  1  one-cycle pulse when the stop bit reads 0
- overrun  output  1  one-cycle pulse when a good frame is dropped because the buffer is full

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. No state is visited without en=1.
- IDLE:
  - en=1 and din=0 (start bit): go to DATA; bit counter cnt=0.
  - en=1 and din=1: stay in IDLE.
- DATA, on each en=1:
  - shreg <= {din, shreg[WIDTH-1:1]}, so the first data bit lands in bit 0.
  - cnt++.
  - When cnt reaches WIDTH-1 (the last data bit is consumed): go to PARITY if PARITY_EN=1, else to STOP.
- PARITY, on en=1: store din as pbit; go to STOP.
- STOP, on en=1:
  - din=1: the frame is good.
  - din=0: pulse framing_err for one cycle and discard the frame.
  - In both cases go to IDLE.
- Parity computation: the parity error flag is the XOR of all shreg bits and pbit. 1 means an error.
- A parity error does not drop the word. The word is buffered with parity_err=1.
- Output buffer, on a good frame:
  - Buffer empty, or dout_valid=1 and dout_ready=1 in the same cycle: load dout and parity_err, and set dout_valid=1. No overrun.
  - dout_valid=1 and dout_ready=0: keep the old word, drop the new one, pulse overrun.
- dout_valid=1 and dout_ready=1 with no completing frame: clear dout_valid next cycle. dout keeps its last value.
- en=0 in any state: no state change, no shift. Gaps between strobes are unbounded.
- reset=1 (any state, including mid-frame), next cycle:
  - FSM=IDLE, cnt=0, shreg=0, pbit=0.
  - dout=0, dout_valid=0, parity_err=0, framing_err=0, overrun=0.
  - Reset overrides en and dout_ready in the same cycle.

## Timing
- Reset value of every output is 0.
- Latency: dout_valid rises on the clock edge after the cycle where en=1 samples the stop bit.
- framing_err and overrun assert on that same edge and last exactly one cycle.
- Back-to-back frames are supported. A start bit may be sampled on the first en after the stop bit; there is no dead cycle.
- Handshake: a transfer occurs on a posedge where dout_valid=1 and dout_ready=1. dout_ready is ignored while dout_valid=0.
- Throughput: one word per (WIDTH + 2 + PARITY_EN) strobes.

## Structure
- Shared package serial_pkg holds:
  - the state typedef, with the 2-bit encoding IDLE=0, DATA=1, PARITY=2, STOP=3;
  - the STOP_LEVEL=1'b1 and START_LEVEL=1'b0 constants.
- Sub-module shift_reg_en: WIDTH-bit right-shift register with an enable and the same synchronous active-high reset. It holds shreg.
- The top module holds the FSM, cnt ($clog2(WIDTH) bits), pbit and the output buffer.

## Test plan
- Good frame with parity:
  - Stimulus: WIDTH=8, PARITY_EN=1, en every cycle. Send 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Response: dout=0xA5, dout_valid=1 and parity_err=0 on the edge after the stop strobe.
- Parity error and framing error:
  - Stimulus: send 0x3C with parity bit 1.
  - Response: dout=0x3C with parity_err=1.
  - Stimulus: then send a frame whose stop bit is 0.
  - Response: framing_err pulses for one cycle; dout_valid stays at its prior value.
- Overrun and simultaneous consume:
  - Stimulus: hold dout_ready=0 and send 0x11, then 0x22.
  - Response: overrun pulses and dout stays 0x11.
  - Stimulus: repeat with dout_ready=1 in the stop-completion cycle of 0x22.
  - Response: dout becomes 0x22, no overrun.
- Sparse strobes:
  - Stimulus: en=1 one cycle in five while sending 0x5A.
  - Response: dout=0x5A. din toggling while en=0 has no effect.
- Reset mid-frame:
  - Stimulus: assert reset after 4 data bits, then send 0xC3 cleanly.
  - Response: all outputs are 0 the cycle after reset; the following frame yields dout=0xC3 with no error.
- No-parity build:
  - Stimulus: WIDTH=5, PARITY_EN=0. Send 0, bits 1,1,0,0,1, stop 1.
  - Response: dout=5'h13, parity_err=0, latency per ## Timing.
